// File: rtl/register_file_mp_pkg.sv
// Shared types and constants for the multi-port register file and its busy scoreboard.
package register_file_mp_pkg;

  localparam int DEFAULT_XLEN      = 32;
  localparam int DEFAULT_REG_COUNT = 32;
  localparam int REG_ZERO          = 0;

  typedef logic [$clog2(DEFAULT_REG_COUNT)-1:0] reg_index_t;
  typedef logic [DEFAULT_XLEN-1:0]              xlen_word_t;

endpackage

// File: rtl/register_file_mp_scoreboard.sv
// regfile_scoreboard: per-register busy bits, reservation accept and clear-on-write.
// REGFILE_BYPASS_EN lets a same-cycle write mask busy and satisfy a reservation.
module regfile_scoreboard
  import register_file_mp_pkg::*;
#(
  parameter int REG_COUNT   = DEFAULT_REG_COUNT,
  parameter int WRITE_PORTS = 2,
  localparam int AW         = $clog2(REG_COUNT)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [WRITE_PORTS-1:0]    writeEnable,
  input  logic [WRITE_PORTS*AW-1:0] writeAddress,
  input  logic                      reserveValid,
  input  logic [AW-1:0]             reserveAddress,
  output logic                      reserveReady,
  output logic [REG_COUNT-1:0]      busyView
);

  logic [REG_COUNT-1:0] busy;
  logic [REG_COUNT-1:0] writeHit;
  logic [REG_COUNT-1:0] nextBusy;
  logic                 accept;

  always_comb begin
    writeHit = '0;
    for (int p = 0; p < WRITE_PORTS; p++)
      if (writeEnable[p]) writeHit[writeAddress[p*AW +: AW]] = 1'b1;
    writeHit[REG_ZERO] = 1'b0;
  end

`ifdef REGFILE_BYPASS_EN
  assign reserveReady = reserveValid & (~busy[reserveAddress] | writeHit[reserveAddress]);
`else
  assign reserveReady = reserveValid & ~busy[reserveAddress];
`endif

  assign accept = reserveReady && (reserveAddress != AW'(REG_ZERO));

  // Reservation is applied after the write clear, so it wins on a same-index collision.
  always_comb begin
    nextBusy = busy & ~writeHit;
    if (accept) nextBusy[reserveAddress] = 1'b1;
    nextBusy[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) busy <= '0;
    else       busy <= nextBusy;
  end

`ifdef REGFILE_BYPASS_EN
  always_comb begin
    busyView = busy & ~writeHit;
    if (accept && writeHit[reserveAddress]) busyView[reserveAddress] = 1'b1;
  end
`else
  assign busyView = busy;
`endif

endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with busy scoreboard; x0 reads as zero.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to the read ports.
module register_file_mp
  import register_file_mp_pkg::*;
#(
  parameter int XLEN        = DEFAULT_XLEN,
  parameter int REG_COUNT   = DEFAULT_REG_COUNT,
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  localparam int AW         = $clog2(REG_COUNT)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [READ_PORTS*AW-1:0]     readAddress,
  output logic [READ_PORTS*XLEN-1:0]   readData,
  output logic [READ_PORTS-1:0]        readBusy,
  input  logic [WRITE_PORTS-1:0]       writeEnable,
  input  logic [WRITE_PORTS*AW-1:0]    writeAddress,
  input  logic [WRITE_PORTS*XLEN-1:0]  writeData,
  input  logic                         reserveValid,
  input  logic [AW-1:0]                reserveAddress,
  output logic                         reserveReady,
  output logic [REG_COUNT*XLEN-1:0]    debugRegsFlat
);

  logic [REG_COUNT-1:0][XLEN-1:0] regView;
  logic [REG_COUNT-1:0]           busyView;

  assign regView[0] = '0;

  // Later write ports overwrite earlier ones, giving the highest index priority.
  for (genvar r = 1; r < REG_COUNT; r++) begin : gReg
    logic [XLEN-1:0] value;
    logic [XLEN-1:0] nextValue;

    always_comb begin
      nextValue = value;
      for (int p = 0; p < WRITE_PORTS; p++)
        if (writeEnable[p] && writeAddress[p*AW +: AW] == AW'(r))
          nextValue = writeData[p*XLEN +: XLEN];
    end

    always_ff @(posedge clock) begin
      if (reset) value <= '0;
      else       value <= nextValue;
    end

    assign regView[r] = value;
  end

  assign debugRegsFlat = regView;

  for (genvar rp = 0; rp < READ_PORTS; rp++) begin : gRead
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] value;

    assign addr = readAddress[rp*AW +: AW];

    always_comb begin
      value = regView[addr];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < WRITE_PORTS; p++)
        if (writeEnable[p] && writeAddress[p*AW +: AW] == addr && addr != AW'(REG_ZERO))
          value = writeData[p*XLEN +: XLEN];
`endif
    end

    assign readData[rp*XLEN +: XLEN] = value;
    assign readBusy[rp]              = busyView[addr];
  end

  regfile_scoreboard #(
    .REG_COUNT  (REG_COUNT),
    .WRITE_PORTS(WRITE_PORTS)
  ) scoreboard (
    .clock         (clock),
    .reset         (reset),
    .writeEnable   (writeEnable),
    .writeAddress  (writeAddress),
    .reserveValid  (reserveValid),
    .reserveAddress(reserveAddress),
    .reserveReady  (reserveReady),
    .busyView      (busyView)
  );

endmodule
